// File: rtl/mw_ctrl_pkg.sv
// Shared definitions for the Microwatt control slave: register map, AXI
// response codes, reset-sequencer state encoding and the byte-strobe merge.
package mw_ctrl_pkg;

  localparam logic [2:0] IDX_CTRL    = 3'd0;
  localparam logic [2:0] IDX_VECTOR  = 3'd1;
  localparam logic [2:0] IDX_STATUS  = 3'd2;
  localparam logic [2:0] IDX_SCRATCH = 3'd3;
  localparam logic [2:0] IDX_CYCLE   = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    SEQ_OFF  = 2'd0,
    SEQ_HOLD = 2'd1,
    SEQ_RUN  = 2'd2
  } seq_state_e;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mw_ctrl_rst_seq.sv
// OFF/HOLD/RUN core reset sequencer: holds the core in reset for
// RST_HOLD_CYCLES cycles after RUN is set and latches the boot vector.
module mw_ctrl_rst_seq
  import mw_ctrl_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES      = 16,
  parameter logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        run_set,
  input  logic        run_clr,
  input  logic [31:0] vector,
  output logic        core_rst_n,
  output logic [31:0] core_reset_addr,
  output logic        hold_active
);

  localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD_CYCLES - 1);

  seq_state_e state_q, state_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      SEQ_OFF: begin
        if (run_set) begin
          state_d    = SEQ_HOLD;
          hold_cnt_d = '0;
        end
      end
      SEQ_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) state_d = SEQ_RUN;
        else                         hold_cnt_d = hold_cnt_q + 8'd1;
      end
      SEQ_RUN: state_d = SEQ_RUN;
      default: state_d = SEQ_OFF;
    endcase
    if (run_clr) state_d = SEQ_OFF;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q         <= SEQ_OFF;
      hold_cnt_q      <= '0;
      core_rst_n      <= 1'b0;
      core_reset_addr <= RESET_VECTOR_DEFAULT;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      // Registered so the core reset never glitches on a state decode.
      core_rst_n <= (state_d == SEQ_RUN);
      if (state_q == SEQ_OFF && state_d == SEQ_HOLD) core_reset_addr <= vector;
    end
  end

  assign hold_active = (state_q == SEQ_HOLD);

endmodule

// File: rtl/mw_ctrl_slave.sv
// AXI4-Lite control slave for a Microwatt core: CTRL/VECTOR/STATUS/SCRATCH
// registers driving the core reset sequencer. Define MW_CTRL_CYCLE_CNT_EN to
// map a read-only RUN cycle counter at offset 0x10.
module mw_ctrl_slave
  import mw_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH           = 32,
  parameter int unsigned DATA_WIDTH           = 32,
  parameter int unsigned RST_HOLD_CYCLES      = 16,
  parameter logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic                    core_rst_n,
  output logic [31:0]             core_reset_addr
);

  logic        out_of_reset;
  logic        aw_full, w_full;
  logic [2:0]  aw_idx_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        run_q;
  logic [31:0] vector_q, scratch_q;
  logic        hold_active;

  logic        aw_hs, w_hs, ar_hs, commit;
  logic [2:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_ok, ctrl_we, vector_we, scratch_we, run_set, run_clr;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

  // Readies stay low until the first edge after reset release.
  assign s_axi_awready = out_of_reset & ~aw_full;
  assign s_axi_wready  = out_of_reset & ~w_full;
  assign s_axi_arready = out_of_reset & ~s_axi_rvalid;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  // Commit on the edge where the second half of the write arrives.
  assign wr_idx  = aw_full ? aw_idx_q : s_axi_awaddr[4:2];
  assign wr_data = w_full ? w_data_q : 32'(s_axi_wdata);
  assign wr_strb = w_full ? w_strb_q : 4'(s_axi_wstrb);
  assign commit  = (aw_full | aw_hs) & (w_full | w_hs) & ~s_axi_bvalid;

  always_comb begin
    wr_ok = 1'b0;
    case (wr_idx)
      IDX_CTRL, IDX_VECTOR, IDX_SCRATCH: wr_ok = 1'b1;
      default:                           wr_ok = 1'b0;
    endcase
  end

  assign ctrl_we    = commit & wr_ok & (wr_idx == IDX_CTRL);
  assign vector_we  = commit & wr_ok & (wr_idx == IDX_VECTOR);
  assign scratch_we = commit & wr_ok & (wr_idx == IDX_SCRATCH);
  assign run_set    = ctrl_we & wr_strb[0] &  wr_data[0] & ~run_q;
  assign run_clr    = ctrl_we & wr_strb[0] & ~wr_data[0];

`ifdef MW_CTRL_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                       cycle_cnt_q <= '0;
    else if (!core_rst_n && !hold_active) cycle_cnt_q <= '0;
    else if (core_rst_n)                cycle_cnt_q <= cycle_cnt_q + 32'd1;
  end
`endif

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (s_axi_araddr[4:2])
      IDX_CTRL:    rd_data = {31'b0, run_q};
      IDX_VECTOR:  rd_data = vector_q;
      IDX_STATUS:  rd_data = {30'b0, hold_active, core_rst_n};
      IDX_SCRATCH: rd_data = scratch_q;
`ifdef MW_CTRL_CYCLE_CNT_EN
      IDX_CYCLE:   rd_data = cycle_cnt_q;
`endif
      default:     rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_of_reset <= 1'b0;
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      aw_idx_q     <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
      s_axi_rvalid <= 1'b0;
      s_axi_rresp  <= RESP_OKAY;
      s_axi_rdata  <= '0;
    end else begin
      out_of_reset <= 1'b1;
      if (aw_hs) begin
        aw_full  <= 1'b1;
        aw_idx_q <= s_axi_awaddr[4:2];
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= 32'(s_axi_wdata);
        w_strb_q <= 4'(s_axi_wstrb);
      end
      if (commit) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
        aw_full      <= 1'b0;
        w_full       <= 1'b0;
      end
      if (ar_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= DATA_WIDTH'(rd_data);
        s_axi_rresp  <= rd_resp;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run_q     <= 1'b0;
      vector_q  <= RESET_VECTOR_DEFAULT;
      scratch_q <= '0;
    end else begin
      if (ctrl_we && wr_strb[0]) run_q <= wr_data[0];
      if (vector_we)  vector_q  <= apply_strb(vector_q, wr_data, wr_strb);
      if (scratch_we) scratch_q <= apply_strb(scratch_q, wr_data, wr_strb);
    end
  end

  mw_ctrl_rst_seq #(
    .RST_HOLD_CYCLES      (RST_HOLD_CYCLES),
    .RESET_VECTOR_DEFAULT (RESET_VECTOR_DEFAULT)
  ) u_rst_seq (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .run_set         (run_set),
    .run_clr         (run_clr),
    .vector          (vector_q),
    .core_rst_n      (core_rst_n),
    .core_reset_addr (core_reset_addr),
    .hold_active     (hold_active)
  );

endmodule
